fetch_sequencer: RTL and testbench

//  Fetch-stage controller that owns the architectural PC and sequences instruction fetch.

---
 rtl/fetch_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, sequences variable-latency instruction fetch and
// merges EX redirects with ID stalls. Define FETCH_PERF_EN to add saturating perf counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef FETCH_PERF_EN
  , parameter int unsigned PERF_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        flush_ifid
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_wait_cycles,
  output logic [PERF_W-1:0] perf_redirects
`endif
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, REQ, HOLD} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        req_q;
  logic        pend_valid_q;
  logic [31:0] pend_target_q;
  logic [31:0] hold_q;
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_pc_plus4_q;
  logic [31:0] if_instr_q;
  logic        flush_q;
  logic [31:0] redir_tgt;

  assign redir_tgt   = {redirect_target[31:2], 2'b00};
  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_plus4_q;
  assign if_instr    = if_instr_q;
  assign flush_ifid  = flush_q;

  // Fetch FSM; every output above is a direct register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      req_q         <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      hold_q        <= 32'h0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'h0;
      if_pc_plus4_q <= 32'h0;
      if_instr_q    <= NOP_INSTR;
      flush_q       <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      unique case (state_q)
        BOOT: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            if (redirect_valid || pend_valid_q) begin
              pc_q         <= redirect_valid ? redir_tgt : pend_target_q;
              pend_valid_q <= 1'b0;
              if_valid_q   <= 1'b0;
              flush_q      <= 1'b1;
            end else if (stall) begin
              hold_q  <= imem_rdata;
              state_q <= HOLD;
              req_q   <= 1'b0;
            end else begin
              if_pc_q       <= pc_q;
              if_pc_plus4_q <= pc_q + 32'd4;
              if_instr_q    <= imem_rdata;
              if_valid_q    <= 1'b1;
              pc_q          <= pc_q + 32'd4;
            end
          end else begin
            // Outstanding request stays live; its data is dropped when it returns.
            if (redirect_valid) begin
              pend_valid_q  <= 1'b1;
              pend_target_q <= redir_tgt;
            end
            if (redirect_valid || !stall) begin
              if_valid_q <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_q       <= redir_tgt;
            if_valid_q <= 1'b0;
            flush_q    <= 1'b1;
            state_q    <= REQ;
            req_q      <= 1'b1;
          end else if (!stall) begin
            if_pc_q       <= pc_q;
            if_pc_plus4_q <= pc_q + 32'd4;
            if_instr_q    <= hold_q;
            if_valid_q    <= 1'b1;
            pc_q          <= pc_q + 32'd4;
            state_q       <= REQ;
            req_q         <= 1'b1;
          end
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [PERF_W-1:0] perf_stall_q;
  logic [PERF_W-1:0] perf_wait_q;
  logic [PERF_W-1:0] perf_redir_q;

  assign perf_stall_cycles = perf_stall_q;
  assign perf_wait_cycles  = perf_wait_q;
  assign perf_redirects    = perf_redir_q;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_wait_q  <= '0;
      perf_redir_q <= '0;
    end else begin
      if (stall && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + PERF_W'(1);
      end
      if ((state_q == REQ) && !imem_ready && (perf_wait_q != '1)) begin
        perf_wait_q <= perf_wait_q + PERF_W'(1);
      end
      if (redirect_valid && (state_q != BOOT) && (perf_redir_q != '1)) begin
        perf_redir_q <= perf_redir_q + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand-written
// reset/wrap sequences, then randomized traffic against a behavioural model.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        flush_ifid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_wait_cycles;
  logic [31:0] perf_redirects;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .if_instr        (if_instr),
    .flush_ifid      (flush_ifid)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_wait_cycles  (perf_wait_cycles),
    .perf_redirects    (perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hA7, a[23:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rt;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
    logic        e_flush;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rt,
                              input logic rdy, input logic e_req, input logic [31:0] e_addr,
                              input logic e_v, input logic [31:0] e_pc, input logic e_flush);
    vec_t v;
    v.st = st; v.rv = rv; v.rt = rt; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc;
    v.e_pc4 = e_pc + 32'd4; v.e_instr = mem_word(e_pc); v.e_flush = e_flush;
    return v;
  endfunction

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bundle(input string tag, input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc, input logic [31:0] pc4,
                              input logic [31:0] instr, input logic fl);
    check({tag, " imem_req"},    32'(imem_req),   32'(req));
    check({tag, " imem_addr"},   imem_addr,       addr);
    check({tag, " if_valid"},    32'(if_valid),   32'(v));
    check({tag, " if_pc"},       if_pc,           pc);
    check({tag, " if_pc_plus4"}, if_pc_plus4,     pc4);
    check({tag, " if_instr"},    if_instr,        instr);
    check({tag, " flush_ifid"},  32'(flush_ifid), 32'(fl));
  endtask

  // Behavioural reference: fetch engine described by its externally visible rules.
  bit          m_booted, m_holding, m_valid, m_flush;
  logic [31:0] m_pc, m_held, m_bpc, m_bpc4, m_binstr;
  logic [31:0] m_pend[$];
  int unsigned m_stalls, m_waits, m_redirs;

  task automatic model_reset();
    m_booted = 0; m_holding = 0; m_valid = 0; m_flush = 0;
    m_pc = 32'h0; m_held = 32'h0; m_bpc = 32'h0; m_bpc4 = 32'h0; m_binstr = NOP;
    m_pend.delete();
    m_stalls = 0; m_waits = 0; m_redirs = 0;
  endtask

  task automatic model_publish(input logic [31:0] word);
    m_bpc = m_pc; m_bpc4 = m_pc + 32'd4; m_binstr = word; m_valid = 1;
    m_pc = m_pc + 32'd4;
  endtask

  task automatic model_step(input logic st, input logic rv, input logic [31:0] rt,
                            input logic rdy, input logic [31:0] rd);
    logic [31:0] tgt;
    tgt = rt & 32'hFFFF_FFFC;
    m_flush = 0;
    if (st && m_stalls != 32'hFFFF_FFFF) m_stalls++;
    if (m_booted && !m_holding && !rdy && m_waits != 32'hFFFF_FFFF) m_waits++;
    if (m_booted && rv && m_redirs != 32'hFFFF_FFFF) m_redirs++;
    if (!m_booted) begin
      m_booted = 1;
    end else if (m_holding) begin
      if (rv) begin
        m_pc = tgt; m_valid = 0; m_flush = 1; m_holding = 0;
      end else if (!st) begin
        model_publish(m_held); m_holding = 0;
      end
    end else if (rdy) begin
      if (rv || m_pend.size() != 0) begin
        m_pc = rv ? tgt : m_pend[$];
        m_pend.delete();
        m_valid = 0; m_flush = 1;
      end else if (st) begin
        m_holding = 1; m_held = rd;
      end else begin
        model_publish(rd);
      end
    end else begin
      if (rv) m_pend.push_back(tgt);
      if (rv || !st) m_valid = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    check_bundle(tag, !m_holding, m_pc, m_valid, m_bpc, m_bpc4, m_binstr, m_flush);
`ifdef FETCH_PERF_EN
    check({tag, " perf_stall"}, perf_stall_cycles, m_stalls);
    check({tag, " perf_wait"},  perf_wait_cycles,  m_waits);
    check({tag, " perf_redir"}, perf_redirects,    m_redirs);
`endif
  endtask

  task automatic drive(input logic st, input logic rv, input logic [31:0] rt, input logic rdy);
    stall = st; redirect_valid = rv; redirect_target = rt; imem_ready = rdy;
    imem_rdata = mem_word(imem_addr);
  endtask

  initial begin
    vec_t v;
    logic [31:0] redir_before;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    imem_ready = 1'b1; imem_rdata = 32'h0;
    redir_before = 32'h0;

    repeat (2) edge_sample();
    check_bundle("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, NOP, 1'b0);
    rst = 1'b0;

    // Directed table: streaming, wait states, redirect while waiting, stall then redirect.
    v = mk(0,0,0,1, 1,32'h000,0,32'h000,0); v.e_pc4 = 32'h0; v.e_instr = NOP; vecs.push_back(v);
    vecs.push_back(mk(0,0,0,1,          1,32'h004,1,32'h000,0));
    vecs.push_back(mk(0,0,0,1,          1,32'h008,1,32'h004,0));
    vecs.push_back(mk(0,0,0,1,          1,32'h00C,1,32'h008,0));
    vecs.push_back(mk(0,0,0,1,          1,32'h010,1,32'h00C,0));
    vecs.push_back(mk(0,0,0,0,          1,32'h010,0,32'h00C,0));
    vecs.push_back(mk(0,0,0,0,          1,32'h010,0,32'h00C,0));
    vecs.push_back(mk(0,0,0,0,          1,32'h010,0,32'h00C,0));
    vecs.push_back(mk(0,0,0,1,          1,32'h014,1,32'h010,0));
    vecs.push_back(mk(0,0,0,1,          1,32'h018,1,32'h014,0));
    vecs.push_back(mk(0,0,0,1,          1,32'h01C,1,32'h018,0));
    vecs.push_back(mk(0,0,0,1,          1,32'h020,1,32'h01C,0));
    vecs.push_back(mk(0,1,32'h200,0,    1,32'h020,0,32'h01C,0));
    vecs.push_back(mk(0,0,0,0,          1,32'h020,0,32'h01C,0));
    vecs.push_back(mk(0,0,0,1,          1,32'h200,0,32'h01C,1));
    vecs.push_back(mk(0,0,0,1,          1,32'h204,1,32'h200,0));
    vecs.push_back(mk(1,0,0,1,          0,32'h204,1,32'h200,0));
    vecs.push_back(mk(1,0,0,1,          0,32'h204,1,32'h200,0));
    vecs.push_back(mk(1,1,32'h300,1,    1,32'h300,0,32'h200,1));
    vecs.push_back(mk(1,0,0,1,          0,32'h300,0,32'h200,0));
    vecs.push_back(mk(0,0,0,1,          1,32'h304,1,32'h300,0));
    vecs.push_back(mk(0,0,0,1,          1,32'h308,1,32'h304,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].rv, vecs[i].rt, vecs[i].rdy);
      edge_sample();
      check_bundle($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_v,
                   vecs[i].e_pc, vecs[i].e_pc4, vecs[i].e_instr, vecs[i].e_flush);
    end

    // Async reset while a request is outstanding.
    drive(0, 0, 0, 0);
    edge_sample();
    #2;
    rst = 1'b1;
    #1;
    check_bundle("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, NOP, 1'b0);
    edge_sample();
    rst = 1'b0;
    drive(0, 0, 0, 1);
    edge_sample();
    check_bundle("restart_boot", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, NOP, 1'b0);
    drive(0, 0, 0, 1);
    edge_sample();
    check_bundle("restart_first", 1'b1, 32'h4, 1'b1, 32'h0, 32'h4, mem_word(32'h0), 1'b0);

    // PC wrap at the top of the address space, then a misaligned redirect target.
    drive(0, 1, 32'hFFFF_FFFF, 1);
    edge_sample();
    check_bundle("wrap_redir", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h4, mem_word(32'h0), 1'b1);
    drive(0, 0, 0, 1);
    edge_sample();
    check_bundle("wrap_pub", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC), 1'b0);
`ifdef FETCH_PERF_EN
    redir_before = perf_redirects;
`endif
    drive(0, 1, 32'h0000_0103, 1);
    edge_sample();
    check_bundle("align_redir", 1'b1, 32'h100, 1'b0, 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC), 1'b1);
`ifdef FETCH_PERF_EN
    check("perf_redir_once", perf_redirects, redir_before + 32'd1);
`endif
    drive(0, 0, 0, 1);
    edge_sample();
    check_bundle("align_pub", 1'b1, 32'h104, 1'b1, 32'h100, 32'h104, mem_word(32'h100), 1'b0);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    edge_sample();
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      stall           = ($urandom_range(3) == 0);
      redirect_valid  = ($urandom_range(7) == 0);
      redirect_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                 : 32'($urandom);
      imem_ready      = ($urandom_range(2) != 0);
      imem_rdata      = 32'($urandom);
      edge_sample();
      model_step(stall, redirect_valid, redirect_target, imem_ready, imem_rdata);
      compare_model($sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
